dmem_lat: RTL and testbench

DMEM_LAT -- requirements
Module: dmem_lat

---
 rtl/dmem_lat.sv | 114 +++++++++++
 tb/tb_dmem_lat.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_lat.sv
// rtl/dmem_lat.sv - fixed-latency single-port data memory with byte enables and misalignment detection
module dmem_lat #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8192,
    parameter int LAT       = 5,
    parameter     INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic                i_we,
    input  logic [DATA_W/8-1:0] i_be,
    input  logic [31:0]         i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    output logic                o_ready,
    output logic                o_rvd,
    output logic [DATA_W-1:0]   o_rdata,
    output logic                o_wack,
    output logic                o_err
);
    localparam int NB       = DATA_W / 8;
    localparam int ADDR_LSB = $clog2(NB);
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int AW       = IDX_W + ADDR_LSB;
    localparam int CNT_W    = $clog2(LAT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               pend, pend_nx;
    logic               accept;

    logic               we_q;
    logic [NB-1:0]      be_q;
    logic [IDX_W-1:0]   idx_q;
    logic               mis_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               unused_addr;
    assign unused_addr = ^i_addr[31:AW];

    assign accept = (state == IDLE) && i_req;

    // pend marks "the response is registered at the coming edge"; it is only ever set while returning to IDLE
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pend_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (i_req) begin
                    if (LAT == 1) begin
                        pend_nx = 1'b1;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(LAT - 1)) begin
                    state_nx = IDLE;
                    pend_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pend    <= 1'b0;
            o_ready <= 1'b1;
            o_rvd   <= 1'b0;
            o_wack  <= 1'b0;
            o_err   <= 1'b0;
            o_rdata <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            pend    <= pend_nx;
            o_ready <= (state_nx == IDLE);
            o_rvd   <= pend && !mis_q && !we_q;
            o_wack  <= pend && !mis_q && we_q;
            o_err   <= pend && mis_q;
            o_rdata <= (pend && !mis_q && !we_q) ? mem[idx_q] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= i_we;
            be_q    <= i_be;
            idx_q   <= i_addr[AW-1:ADDR_LSB];
            mis_q   <= |i_addr[ADDR_LSB-1:0];
            wdata_q <= i_wdata;
        end
    end

    // pend is cleared asynchronously by rst, so an aborted request never commits
    always_ff @(posedge clk) begin
        if (pend && we_q && !mis_q) begin
            for (int b = 0; b < NB; b++) begin
                if (be_q[b]) mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_lat.sv
// tb/tb_dmem_lat.sv - directed vector bench for dmem_lat at LAT=5 and LAT=1
module tb_dmem_lat;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        req = 1'b0, we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        ready, rvd, wack, err;

    logic        req1 = 1'b0, we1 = 1'b0;
    logic [3:0]  be1 = '0;
    logic [31:0] addr1 = '0, wdata1 = '0, rdata1;
    logic        ready1, rvd1, wack1, err1;

    int errors = 0;
    int checks = 0;

    dmem_lat #(.DATA_W(32), .DEPTH(8192), .LAT(5), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst), .i_req(req), .i_we(we), .i_be(be), .i_addr(addr),
        .i_wdata(wdata), .o_ready(ready), .o_rvd(rvd), .o_rdata(rdata),
        .o_wack(wack), .o_err(err)
    );

    dmem_lat #(.DATA_W(32), .DEPTH(16), .LAT(1), .INIT_FILE("")) dut1 (
        .clk(clk), .rst(rst), .i_req(req1), .i_we(we1), .i_be(be1), .i_addr(addr1),
        .i_wdata(wdata1), .o_ready(ready1), .o_rvd(rvd1), .o_rdata(rdata1),
        .o_wack(wack1), .o_err(err1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // flags are {o_err, o_wack, o_rvd}; lat counts edges from acceptance to the registered response
    task automatic do_req(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int busy, output logic [2:0] flags, output logic [31:0] rd);
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; we = ~w; be = ~b; addr = 32'hFFFF_FFFC; wdata = ~d;
        lat = -1; busy = 0; flags = '0; rd = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rvd || wack || err) begin
                lat = k - 1; flags = {err, wack, rvd}; rd = rdata;
                break;
            end
            if (!ready) busy++;
        end
    endtask

    typedef struct {
        logic        w;
        logic [3:0]  b;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  exp_flags;
        logic [31:0] exp_rd;
    } vec_t;

    localparam logic [2:0] F_RVD = 3'b001, F_WACK = 3'b010, F_ERR = 3'b100;

    initial begin
        vec_t        v [12];
        int          lat, busy, k;
        logic [2:0]  flags;
        logic [31:0] rd;
        logic        saw;

        v[0]  = '{1'b1, 4'hF, 32'h0000_0040, 32'hDEAD_BEEF, F_WACK, 32'h0};
        v[1]  = '{1'b0, 4'h0, 32'h0000_0040, 32'h0,         F_RVD,  32'hDEAD_BEEF};
        v[2]  = '{1'b1, 4'hF, 32'h0000_0080, 32'hFFFF_FFFF, F_WACK, 32'h0};
        v[3]  = '{1'b1, 4'h5, 32'h0000_0080, 32'h1122_3344, F_WACK, 32'h0};
        v[4]  = '{1'b0, 4'hF, 32'h0000_0080, 32'h0,         F_RVD,  32'hFF22_FF44};
        v[5]  = '{1'b0, 4'hF, 32'h0000_0042, 32'h0,         F_ERR,  32'h0};
        v[6]  = '{1'b1, 4'hF, 32'h0000_0043, 32'h0,         F_ERR,  32'h0};
        v[7]  = '{1'b0, 4'h0, 32'h0000_0040, 32'h0,         F_RVD,  32'hDEAD_BEEF};
        v[8]  = '{1'b1, 4'h0, 32'h0000_0080, 32'h1234_5678, F_WACK, 32'h0};
        v[9]  = '{1'b0, 4'h0, 32'h0000_0080, 32'h0,         F_RVD,  32'hFF22_FF44};
        v[10] = '{1'b1, 4'hF, 32'h0000_0100, 32'hCAFE_F00D, F_WACK, 32'h0};
        v[11] = '{1'b0, 4'h0, 32'h0002_0080, 32'h0,         F_RVD,  32'hFF22_FF44};

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'h1);
        chk("rst_flags", {29'b0, err, wack, rvd}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ready1", {31'b0, ready1}, 32'h1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            chk($sformatf("v%0d_ready_before", i), {31'b0, ready}, 32'h1);
            do_req(v[i].w, v[i].b, v[i].a, v[i].d, lat, busy, flags, rd);
            chk($sformatf("v%0d_latency", i), lat, 32'd5);
            chk($sformatf("v%0d_busy", i), busy, 32'd4);
            chk($sformatf("v%0d_flags", i), {29'b0, flags}, {29'b0, v[i].exp_flags});
            chk($sformatf("v%0d_rdata", i), rd, v[i].exp_rd);
            chk($sformatf("v%0d_ready_resp", i), {31'b0, ready}, 32'h1);
            @(negedge clk);
            chk($sformatf("v%0d_pulse_end", i), {28'b0, err, wack, rvd, |rdata}, 32'h0);
        end

        // i_req held: write 0x8000 (aliases word 0), then read 0x0 accepted in the write's response cycle
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h0000_8000; wdata = 32'h5A5A_A5A5;
        @(posedge clk);
        #1;
        we = 1'b0; addr = 32'h0; wdata = 32'h0;
        k = 0;
        saw = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (wack) begin k = j; saw = 1'b1; break; end
        end
        chk("b2b_wack_seen", {31'b0, saw}, 32'h1);
        chk("b2b_wack_lat", k, 32'd6);
        chk("b2b_read_accepted", {31'b0, ready}, 32'h0);
        req = 1'b0;
        k = 0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (rvd) begin k = j; break; end
        end
        chk("b2b_read_lat", k, 32'd5);
        chk("b2b_read_data", rdata, 32'h5A5A_A5A5);
        @(negedge clk);

        // reset two cycles into a write to 0x100; the earlier 0xCAFEF00D must survive
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h0000_0100; wdata = 32'h0BAD_0BAD;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", {31'b0, ready}, 32'h1);
        chk("rst_mid_flags", {29'b0, err, wack, rvd}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_after_ready", {31'b0, ready}, 32'h1);
        saw = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (wack || rvd || err) saw = 1'b1;
        end
        chk("rst_no_response", {31'b0, saw}, 32'h0);
        do_req(1'b0, 4'h0, 32'h0000_0100, 32'h0, lat, busy, flags, rd);
        chk("rst_mem_flags", {29'b0, flags}, {29'b0, F_RVD});
        chk("rst_mem_kept", rd, 32'hCAFE_F00D);
        @(negedge clk);

        // LAT=1: four writes then four reads, i_req never dropped; first read hits the word written one edge earlier
        req1 = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (j < 4) begin
                we1 = 1'b1; be1 = 4'hF; addr1 = 32'(j * 4); wdata1 = 32'h1000 + 32'(j);
            end else begin
                we1 = 1'b0; be1 = 4'h0; addr1 = 32'((7 - j) * 4); wdata1 = 32'h0;
            end
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("l1_ready_%0d", j), {31'b0, ready1}, 32'h1);
            if (j >= 1 && j <= 4) begin
                chk($sformatf("l1_wack_%0d", j - 1), {29'b0, err1, wack1, rvd1}, {29'b0, F_WACK});
            end else if (j > 4) begin
                chk($sformatf("l1_rvd_%0d", j - 1), {29'b0, err1, wack1, rvd1}, {29'b0, F_RVD});
                chk($sformatf("l1_rdata_%0d", j - 1), rdata1, 32'h1000 + 32'(3 - (j - 5)));
            end
        end
        req1 = 1'b0;
        @(negedge clk);
        chk("l1_rvd_7", {29'b0, err1, wack1, rvd1}, {29'b0, F_RVD});
        chk("l1_rdata_7", rdata1, 32'h1000);
        @(negedge clk);
        chk("l1_idle", {29'b0, err1, wack1, rvd1}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
